// File: rtl/mem_bus_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_if_pkg
//   Shared definitions for the memory bus interface: FSM state encodings,
//   bus direction codes, bus widths and the latched request record.
// ---------------------------------------------------------------------------
package mem_bus_if_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    // Bus direction codes
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {
        MEM_BUS_IDLE     = 2'd0,
        MEM_BUS_BUSY     = 2'd1,
        MEM_BUS_COMPLETE = 2'd2
    } mem_bus_state_e;

    // Request as presented on the bus for the duration of an access
    typedef struct packed {
        logic                   rw;
        logic [WORD_ADDR_W-1:0] addr;
        logic [WORD_DATA_W-1:0] wr_data;
    } mem_bus_req_t;

    localparam mem_bus_req_t MEM_BUS_REQ_RST = '{rw: READ, addr: '0, wr_data: '0};

endpackage

// File: rtl/mem_bus_timer.sv
// ---------------------------------------------------------------------------
// mem_bus_timer
//   Counts consecutive cycles while 'run' is high and flags the cycle in
//   which the TIMEOUT_CYCLES-th such cycle is reached.
//
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   run      in   high while the bus access is outstanding
//   expired  out  high during the TIMEOUT_CYCLES-th consecutive run cycle
// ---------------------------------------------------------------------------
module mem_bus_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // count holds the number of run cycles already elapsed, so the
    // terminal cycle is the one in which count equals TIMEOUT_CYCLES-1.
    assign expired = run && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_if.sv
module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_as_,
    input  logic                   req_rw,
    input  logic [WORD_ADDR_W-1:0] req_addr,
    input  logic [WORD_DATA_W-1:0] req_wr_data,
    input  logic                   req_miss_align,
    input  logic                   flush,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic [WORD_DATA_W-1:0] bus_wr_data,
    input  logic                   bus_rdy_,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic                   stall,
    output logic                   done,
    output logic                   bus_err
);

    mem_bus_state_e state, state_nxt;

    mem_bus_req_t   bus_q;
    logic           bus_as_q;
    logic [WORD_DATA_W-1:0] rd_data_q;
    logic           done_q;
    logic           bus_err_q;
    logic           discard_q;
    logic           armed_q;

    logic accept;
    logic rdy;
    logic tmo;
    logic drop;

`ifdef MEM_BUS_TIMEOUT_EN
    mem_bus_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (state == MEM_BUS_BUSY),
        .expired (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        stall     = 1'b0;
        rdy       = 1'b0;
        drop      = discard_q || flush;

        unique case (state)
            MEM_BUS_IDLE: begin
                if (armed_q && !req_as_ && !req_miss_align && !flush) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    state_nxt = MEM_BUS_BUSY;
                end
            end
            MEM_BUS_BUSY: begin
                stall = 1'b1;
                rdy   = !bus_rdy_;
                if (rdy || tmo) begin
                    state_nxt = drop ? MEM_BUS_IDLE : MEM_BUS_COMPLETE;
                end
            end
            MEM_BUS_COMPLETE: begin
                state_nxt = MEM_BUS_IDLE;
            end
            default: begin
                state_nxt = MEM_BUS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MEM_BUS_IDLE;
            bus_q     <= MEM_BUS_REQ_RST;
            bus_as_q  <= 1'b1;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            bus_err_q <= 1'b0;
            discard_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            armed_q   <= 1'b1;
            done_q    <= 1'b0;
            bus_err_q <= 1'b0;

            if (accept) begin
                bus_as_q      <= 1'b0;
                bus_q.rw      <= req_rw;
                bus_q.addr    <= req_addr;
                bus_q.wr_data <= req_wr_data;
            end

            if (state == MEM_BUS_BUSY) begin
                if (flush) begin
                    discard_q <= 1'b1;
                end
                if (rdy) begin
                    bus_as_q  <= 1'b1;
                    discard_q <= 1'b0;
                    if (!drop) begin
                        done_q <= 1'b1;
                        if (bus_q.rw == READ) begin
                            rd_data_q <= bus_rd_data;
                        end
                    end
                end else if (tmo) begin
                    bus_as_q  <= 1'b1;
                    discard_q <= 1'b0;
                    if (!drop) begin
                        done_q    <= 1'b1;
                        bus_err_q <= 1'b1;
                        rd_data_q <= '0;
                    end
                end
            end
        end
    end

    assign bus_as_     = bus_as_q;
    assign bus_rw      = bus_q.rw;
    assign bus_addr    = bus_q.addr;
    assign bus_wr_data = bus_q.wr_data;
    assign rd_data     = rd_data_q;
    assign done        = done_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_bus_if.sv
module tb_mem_bus_if;
    import mem_bus_if_pkg::*;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int unsigned TB_TMO = 4;
`else
    localparam int unsigned TB_TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_as_;
    logic        req_rw;
    logic [29:0] req_addr;
    logic [31:0] req_wr_data;
    logic        req_miss_align;
    logic        flush;
    logic        bus_as_;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic        bus_rdy_;
    logic [31:0] bus_rd_data;
    logic [31:0] rd_data;
    logic        stall;
    logic        done;
    logic        bus_err;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_bus_if #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_as_        (req_as_),
        .req_rw         (req_rw),
        .req_addr       (req_addr),
        .req_wr_data    (req_wr_data),
        .req_miss_align (req_miss_align),
        .flush          (flush),
        .bus_as_        (bus_as_),
        .bus_rw         (bus_rw),
        .bus_addr       (bus_addr),
        .bus_wr_data    (bus_wr_data),
        .bus_rdy_       (bus_rdy_),
        .bus_rd_data    (bus_rd_data),
        .rd_data        (rd_data),
        .stall          (stall),
        .done           (done),
        .bus_err        (bus_err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk1 ({tag, ".bus_as_"}, bus_as_, 1'b1);
        chk1 ({tag, ".bus_rw"}, bus_rw, READ);
        chk32({tag, ".bus_addr"}, {2'b00, bus_addr}, 32'h0);
        chk32({tag, ".bus_wr_data"}, bus_wr_data, 32'h0);
        chk32({tag, ".rd_data"}, rd_data, 32'h0);
        chk1 ({tag, ".done"}, done, 1'b0);
        chk1 ({tag, ".bus_err"}, bus_err, 1'b0);
        chk1 ({tag, ".stall"}, stall, 1'b0);
    endtask

    initial begin
        logic saw_err;
        logic saw_release;

        rst = 1'b1; req_as_ = 1'b1; req_rw = READ; req_addr = '0; req_wr_data = '0;
        req_miss_align = 1'b0; flush = 1'b0; bus_rdy_ = 1'b1; bus_rd_data = '0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        #1;
        chk_reset("por");
        step();

        req_as_ = 1'b0; req_rw = READ; req_addr = 30'h10;
        #1 chk1("rd.T.stall", stall, 1'b1);
        step();
        req_as_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
        #1;
        chk1 ("rd.T1.bus_as_", bus_as_, 1'b0);
        chk1 ("rd.T1.bus_rw", bus_rw, READ);
        chk32("rd.T1.bus_addr", {2'b00, bus_addr}, 32'h10);
        chk1 ("rd.T1.stall", stall, 1'b1);
        step();
        bus_rdy_ = 1'b1;
        req_as_ = 1'b0; req_rw = WRITE; req_addr = 30'h20; req_wr_data = 32'h1234_5678;
        #1;
        chk1 ("rd.T2.bus_as_", bus_as_, 1'b1);
        chk1 ("rd.T2.done", done, 1'b1);
        chk1 ("rd.T2.stall", stall, 1'b0);
        chk32("rd.T2.rd_data", rd_data, 32'hDEAD_BEEF);
        step();
        chk1 ("cmpl.no_accept.bus_as_", bus_as_, 1'b1);
        chk1 ("cmpl.done_one_cycle", done, 1'b0);
        chk1 ("wr.T.stall", stall, 1'b1);

        step();
        req_as_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus_rdy_ = 1'b0; bus_rd_data = 32'hFFFF_FFFF;
            end
            #1;
            chk1 ("wr.busy.bus_as_", bus_as_, 1'b0);
            chk1 ("wr.busy.bus_rw", bus_rw, WRITE);
            chk32("wr.busy.bus_addr", {2'b00, bus_addr}, 32'h20);
            chk32("wr.busy.bus_wr_data", bus_wr_data, 32'h1234_5678);
            chk1 ("wr.busy.stall", stall, 1'b1);
            chk1 ("wr.busy.done", done, 1'b0);
            step();
        end
        bus_rdy_ = 1'b1;
        #1;
        chk1 ("wr.T5.done", done, 1'b1);
        chk1 ("wr.T5.bus_as_", bus_as_, 1'b1);
        chk32("wr.T5.rd_data", rd_data, 32'hDEAD_BEEF);
        step();

        req_as_ = 1'b0; req_rw = READ; req_addr = 30'h55; req_miss_align = 1'b1;
        #1 chk1("mis.stall", stall, 1'b0);
        step();
        #1;
        chk1("mis.bus_as_", bus_as_, 1'b1);
        chk1("mis.stall2", stall, 1'b0);
        step();
        chk1("mis.done", done, 1'b0);
        req_miss_align = 1'b0; flush = 1'b1;
        #1 chk1("fl_idle.stall", stall, 1'b0);
        step();
        chk1("fl_idle.bus_as_", bus_as_, 1'b1);
        flush = 1'b0; req_as_ = 1'b1;
        step();

        req_as_ = 1'b0; req_rw = READ; req_addr = 30'h30;
        step();
        req_as_ = 1'b1;
        #1 chk1("flb.b1.bus_as_", bus_as_, 1'b0);
        step();
        flush = 1'b1;
        #1;
        chk1("flb.b2.stall", stall, 1'b1);
        chk1("flb.b2.bus_as_", bus_as_, 1'b0);
        step();
        flush = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFE_F00D;
        #1 chk1("flb.b3.bus_as_", bus_as_, 1'b0);
        step();
        bus_rdy_ = 1'b1;
        #1;
        chk1 ("flb.done", done, 1'b0);
        chk1 ("flb.bus_as_", bus_as_, 1'b1);
        chk1 ("flb.stall", stall, 1'b0);
        chk32("flb.rd_data", rd_data, 32'hDEAD_BEEF);
        step();
        chk1 ("flb.done2", done, 1'b0);

        req_as_ = 1'b0; req_rw = WRITE; req_addr = 30'h3FFF_FFFF; req_wr_data = 32'hA5A5_A5A5;
        step();
        req_as_ = 1'b1;
        saw_err = 1'b0; saw_release = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
        for (int i = 0; i < 2; i++) begin
`else
        for (int i = 0; i < 300; i++) begin
`endif
            saw_err     = saw_err | bus_err;
            saw_release = saw_release | bus_as_;
            step();
        end
        chk1 ("long.no_bus_err", saw_err, 1'b0);
        chk1 ("long.no_release", saw_release, 1'b0);
        chk32("long.bus_wr_data", bus_wr_data, 32'hA5A5_A5A5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk_reset("midrst");
        step();

`ifdef MEM_BUS_TIMEOUT_EN
        req_as_ = 1'b0; req_rw = READ; req_addr = 30'h40;
        step();
        req_as_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'h1111_1111;
        step();
        bus_rdy_ = 1'b1;
        #1 chk32("tmo.pre.rd_data", rd_data, 32'h1111_1111);
        step();
        req_as_ = 1'b0; req_addr = 30'h44;
        step();
        req_as_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk1("tmo.busy.bus_err", bus_err, 1'b0);
            chk1("tmo.busy.bus_as_", bus_as_, 1'b0);
            step();
        end
        chk1 ("tmo.bus_err", bus_err, 1'b1);
        chk1 ("tmo.done", done, 1'b1);
        chk32("tmo.rd_data", rd_data, 32'h0);
        chk1 ("tmo.bus_as_", bus_as_, 1'b1);
        step();
        chk1 ("tmo.bus_err_pulse", bus_err, 1'b0);
        step();

        req_as_ = 1'b0; req_addr = 30'h48;
        step();
        req_as_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus_rdy_ = 1'b0; bus_rd_data = 32'h2222_2222;
            end
            step();
        end
        bus_rdy_ = 1'b1;
        #1;
        chk1 ("tmo_rdy.done", done, 1'b1);
        chk1 ("tmo_rdy.bus_err", bus_err, 1'b0);
        chk32("tmo_rdy.rd_data", rd_data, 32'h2222_2222);
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
